// File: rtl/tdc_ctrl_pkg.sv
// Shared definitions for the Vernier TDC measurement sequencer.
package tdc_ctrl_pkg;

  localparam int unsigned DELAY_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

endpackage

// File: rtl/tdc_sample_avg.sv
// Accumulates TDC delay words over 2^AVG_LOG2 samples and presents the
// truncated mean; 'last' flags that the next add completes the set.
module tdc_sample_avg
  import tdc_ctrl_pkg::*;
#(
  parameter int unsigned DELAY_W  = DELAY_W_DEF,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               add,
  input  logic               clear,
  input  logic [DELAY_W-1:0] sample,
  output logic               last,
  output logic               full,
  output logic [DELAY_W-1:0] avg_out
);

  localparam int unsigned AW = DELAY_W + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] NSAMP = CW'(1 << AVG_LOG2);

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (add) begin
      acc <= acc + AW'(sample);
      cnt <= cnt + 1'b1;
    end
  end

  assign full    = (cnt == NSAMP);
  assign last    = (cnt == NSAMP - 1'b1);
  assign avg_out = acc[AW-1:AVG_LOG2];

endmodule

// File: rtl/tdc_measure_ctrl.sv
// Vernier TDC sequencer: clear, wait for done, capture, average, and hand the
// result to the loop filter over valid/ready, with missing-edge timeout.
module tdc_measure_ctrl
  import tdc_ctrl_pkg::*;
#(
  parameter int unsigned DELAY_W        = DELAY_W_DEF,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned CLR_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               tdc_rst,
  input  logic               tdc_done,
  input  logic [DELAY_W-1:0] tdc_delay,
  output logic [DELAY_W-1:0] avg_delay,
  output logic               avg_valid,
  input  logic               avg_ready,
  output logic               timeout_err,
  input  logic               err_clear
);

  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CCW = $clog2(CLR_CYCLES + 1);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CCW-1:0] C_LAST = CCW'(CLR_CYCLES - 1);

  state_t             state, next_state;
  logic [TW-1:0]      timer;
  logic [CCW-1:0]     clr_cnt;
  logic               add, acc_clear, set_err, accept;
  logic               last, full;
  logic [DELAY_W-1:0] avg_out;

  assign accept = avg_valid & avg_ready;

  tdc_sample_avg #(
    .DELAY_W  (DELAY_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk     (clk),
    .reset   (reset),
    .add     (add),
    .clear   (acc_clear),
    .sample  (tdc_delay),
    .last    (last),
    .full    (full),
    .avg_out (avg_out)
  );

  // Dropping enable aborts a partial set; done takes precedence over timeout.
  always_comb begin
    next_state = state;
    add        = 1'b0;
    acc_clear  = 1'b0;
    set_err    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        acc_clear = 1'b1;
        if (enable) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!enable) begin
          acc_clear  = 1'b1;
          next_state = ST_IDLE;
        end else if (clr_cnt == C_LAST) begin
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          acc_clear  = 1'b1;
          next_state = ST_IDLE;
        end else if (tdc_done) begin
          add        = 1'b1;
          next_state = last ? ST_OUTPUT : ST_CLEAR;
        end else if (timer == T_LAST) begin
          set_err    = 1'b1;
          next_state = ST_CLEAR;
        end
      end
      ST_OUTPUT: begin
        if (accept) begin
          acc_clear  = 1'b1;
          next_state = enable ? ST_CLEAR : ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      clr_cnt     <= '0;
      tdc_rst     <= 1'b1;
      avg_valid   <= 1'b0;
      avg_delay   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state   <= next_state;
      tdc_rst <= (next_state != ST_WAIT);
      timer   <= (state == ST_WAIT && next_state == ST_WAIT) ? timer + 1'b1 : '0;
      clr_cnt <= (state == ST_CLEAR && next_state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;

      // Result registers one cycle after entering OUTPUT, once the last add has landed.
      if (accept) begin
        avg_valid <= 1'b0;
      end else if (state == ST_OUTPUT && full && !avg_valid) begin
        avg_valid <= 1'b1;
        avg_delay <= avg_out;
      end

      if (set_err)        timeout_err <= 1'b1;
      else if (err_clear) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// Directed bench for tdc_measure_ctrl with a small behavioural TDC responder.
module tb_tdc_measure_ctrl;

  logic        clk = 1'b0;
  logic        reset, enable, avg_ready, err_clear;
  logic        tdc_rst, avg_valid, timeout_err;
  logic        tdc_done = 1'b0;
  logic [11:0] tdc_delay = '0;
  logic [11:0] avg_delay;

  int          checks = 0;
  int          failures = 0;
  int          resp_lat = -1;
  int          ndone = 0;
  int          wc = 0;
  int          base = 0;
  int          n;
  logic [11:0] vals [8];

  tdc_measure_ctrl #(
    .DELAY_W        (12),
    .AVG_LOG2       (2),
    .CLR_CYCLES     (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tdc_rst     (tdc_rst),
    .tdc_done    (tdc_done),
    .tdc_delay   (tdc_delay),
    .avg_delay   (avg_delay),
    .avg_valid   (avg_valid),
    .avg_ready   (avg_ready),
    .timeout_err (timeout_err),
    .err_clear   (err_clear)
  );

  initial forever #5 clk = ~clk;

  // TDC model: done rises resp_lat negedges into the released window, sticky until tdc_rst.
  always @(negedge clk) begin
    if (tdc_rst) begin
      tdc_done = 1'b0;
      wc = 0;
    end else begin
      if (!tdc_done && resp_lat >= 0 && wc == resp_lat) begin
        tdc_done  = 1'b1;
        tdc_delay = vals[(ndone - base) & 7];
        ndone++;
      end
      wc++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wait_rst(input logic lvl, input string tag);
    int k = 0;
    while (tdc_rst !== lvl && k < 500) begin tick(); k++; end
    chk(tag, {31'd0, tdc_rst}, {31'd0, lvl});
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (avg_valid !== 1'b1 && k < 500) begin tick(); k++; end
    chk(tag, {31'd0, avg_valid}, 32'd1);
  endtask

  task automatic wait_done(input int cnt, input string tag);
    int k = 0;
    while ((ndone - base) < cnt && k < 500) begin tick(); k++; end
    chk(tag, ((ndone - base) >= cnt) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic set_vals(input logic [11:0] v0, input logic [11:0] v1,
                          input logic [11:0] v2, input logic [11:0] v3);
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    vals[4] = v0; vals[5] = v1; vals[6] = v2; vals[7] = v3;
    base = ndone;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; avg_ready = 1'b0; err_clear = 1'b0;
    set_vals(12'd0, 12'd0, 12'd0, 12'd0);
    repeat (3) tick();
    chk("rst_tdc_rst", {31'd0, tdc_rst}, 32'd1);
    chk("rst_avg_valid", {31'd0, avg_valid}, 32'd0);
    chk("rst_avg_delay", {20'd0, avg_delay}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: four samples 100..103 -> mean 101, CLEAR lasts two cycles
    set_vals(12'd100, 12'd101, 12'd102, 12'd103);
    resp_lat = 3;
    enable = 1'b1;
    wait_rst(1'b0, "t1_first_wait");
    repeat (3) begin
      wait_rst(1'b1, "t1_clear_start");
      n = 0;
      while (tdc_rst === 1'b1 && n < 50) begin n++; tick(); end
      chk("t1_clear_len", n, 32'd2);
    end
    wait_valid("t1_valid");
    chk("t1_avg", {20'd0, avg_delay}, 32'd101);
    avg_ready = 1'b1; enable = 1'b0;
    tick();
    avg_ready = 1'b0;
    chk("t1_valid_drop", {31'd0, avg_valid}, 32'd0);
    tick(); tick();

    // 2: no done -> error after 16 WAIT cycles, then cleared
    base = ndone;
    resp_lat = -1;
    enable = 1'b1;
    wait_rst(1'b0, "t2_wait");
    chk("t2_err_before", {31'd0, timeout_err}, 32'd0);
    n = 0;
    while (tdc_rst === 1'b0 && n < 100) begin n++; tick(); end
    chk("t2_wait_len", n, 32'd16);
    chk("t2_err_set", {31'd0, timeout_err}, 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t2_err_clear", {31'd0, timeout_err}, 32'd0);
    enable = 1'b0;
    tick(); tick();

    // 3: done coincides with the timeout cycle -> counted, no error
    set_vals(12'd10, 12'd20, 12'd30, 12'd40);
    resp_lat = 15;
    enable = 1'b1;
    wait_valid("t3_valid");
    chk("t3_avg", {20'd0, avg_delay}, 32'd25);
    chk("t3_no_err", {31'd0, timeout_err}, 32'd0);
    resp_lat = -1;

    // 4: back-pressure for 20 cycles, then accept and restart
    repeat (20) begin
      tick();
      chk("t4_hold_valid", {31'd0, avg_valid}, 32'd1);
      chk("t4_hold_delay", {20'd0, avg_delay}, 32'd25);
      chk("t4_hold_rst", {31'd0, tdc_rst}, 32'd1);
    end
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
    chk("t4_accept", {31'd0, avg_valid}, 32'd0);
    chk("t4_clear0", {31'd0, tdc_rst}, 32'd1);
    tick();
    chk("t4_clear1", {31'd0, tdc_rst}, 32'd1);
    tick();
    chk("t4_wait", {31'd0, tdc_rst}, 32'd0);
    enable = 1'b0;
    tick(); tick();

    // 5: abort after two samples, then full-scale set
    set_vals(12'd50, 12'd60, 12'd50, 12'd60);
    resp_lat = 2;
    enable = 1'b1;
    wait_done(2, "t5_two_done");
    tick();
    enable = 1'b0;
    repeat (10) begin
      tick();
      chk("t5_no_valid", {31'd0, avg_valid}, 32'd0);
      chk("t5_idle_rst", {31'd0, tdc_rst}, 32'd1);
    end
    set_vals(12'd4095, 12'd4095, 12'd4095, 12'd4095);
    enable = 1'b1;
    wait_valid("t5_valid");
    chk("t5_avg_max", {20'd0, avg_delay}, 32'd4095);
    avg_ready = 1'b1; enable = 1'b0;
    tick();
    avg_ready = 1'b0;
    tick(); tick();

    // 6: reset during WAIT and during OUTPUT
    set_vals(12'd3000, 12'd3000, 12'd3000, 12'd3000);
    resp_lat = 2;
    enable = 1'b1;
    wait_done(1, "t6_one_done");
    wait_rst(1'b1, "t6_clear");
    wait_rst(1'b0, "t6_wait");
    reset = 1'b1; enable = 1'b0;
    tick();
    chk("t6w_rst", {31'd0, tdc_rst}, 32'd1);
    chk("t6w_valid", {31'd0, avg_valid}, 32'd0);
    chk("t6w_delay", {20'd0, avg_delay}, 32'd0);
    chk("t6w_err", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0;
    tick();
    set_vals(12'd8, 12'd8, 12'd8, 12'd8);
    resp_lat = 1;
    enable = 1'b1;
    wait_valid("t6_valid");
    chk("t6_avg_fresh", {20'd0, avg_delay}, 32'd8);
    reset = 1'b1;
    tick();
    chk("t6o_valid", {31'd0, avg_valid}, 32'd0);
    chk("t6o_delay", {20'd0, avg_delay}, 32'd0);
    chk("t6o_rst", {31'd0, tdc_rst}, 32'd1);
    reset = 1'b0; enable = 1'b0;
    tick(); tick();
    chk("t6o_stays_low", {31'd0, avg_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
